pipe_stage_buffer: RTL and testbench



---
 rtl/pipe_stage_buffer.sv | 83 ++++++++
 tb/tb_pipe_stage_buffer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buffer.sv
// Elastic pipeline stage: DEPTH-entry circular FIFO with valid/ready on both sides and a synchronous flush.
// Optional macro PIPE_STAGE_BUFFER_ORDER_EN adds a 64-bit retirement-order tag (out_order).
module pipe_stage_buffer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef PIPE_STAGE_BUFFER_ORDER_EN
  ,
  output logic [63:0]                out_order
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_reg;
  logic             enq;
  logic             deq;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // in_ready looks only at occupancy, so a full buffer never accepts even while draining.
  assign in_ready  = (count_reg < CNT_W'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign out_data  = mem[rd_ptr];
  assign count     = count_reg;

  assign enq = in_valid & in_ready & ~flush;
  assign deq = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
    end else if (flush) begin
      count_reg <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
    end else begin
      if (enq) wr_ptr <= bump(wr_ptr);
      if (deq) rd_ptr <= bump(rd_ptr);
      case ({enq, deq})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Payload storage carries no reset.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= in_data;
  end

`ifdef PIPE_STAGE_BUFFER_ORDER_EN
  logic [63:0] order_cnt;

  // Flush neither advances nor rewinds the tag; only real retirements consume a number.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   order_cnt <= '0;
    else if (deq) order_cnt <= order_cnt + 64'd1;
  end

  assign out_order = order_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Bench for pipe_stage_buffer: table-driven vectors on a DEPTH=2 instance plus hand sequences
// on a DEPTH=3 instance, all checked against a queue scoreboard.
module tb_pipe_stage_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst_n, a_flush, a_in_valid, a_out_ready;
  logic [31:0] a_in_data;
  logic        a_in_ready, a_out_valid;
  logic [31:0] a_out_data;
  logic [1:0]  a_count;
  logic        b_rst_n, b_flush, b_in_valid, b_out_ready;
  logic [31:0] b_in_data;
  logic        b_in_ready, b_out_valid;
  logic [31:0] b_out_data;
  logic [1:0]  b_count;
`ifdef PIPE_STAGE_BUFFER_ORDER_EN
  logic [63:0] a_out_order, b_out_order;
`endif

  pipe_stage_buffer #(.WIDTH(32), .DEPTH(2)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .count(a_count)
`ifdef PIPE_STAGE_BUFFER_ORDER_EN
    , .out_order(a_out_order)
`endif
  );

  pipe_stage_buffer #(.WIDTH(32), .DEPTH(3)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .count(b_count)
`ifdef PIPE_STAGE_BUFFER_ORDER_EN
    , .out_order(b_out_order)
`endif
  );

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    int          exp_cnt;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  longint unsigned ord_a = 0;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic iv, input logic [31:0] d, input logic ordy,
                              input logic fl, input int exp_cnt);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl; v.exp_cnt = exp_cnt;
    tbl.push_back(v);
  endfunction

  // One clock cycle: drive, check outputs at negedge against the scoreboard, update it, advance.
  task automatic cyc(input int sel, input logic iv, input logic [31:0] d,
                     input logic ordy, input logic fl);
    int sz;
    if (sel == 0) begin
      a_in_valid = iv; a_in_data = d; a_out_ready = ordy; a_flush = fl;
    end else begin
      b_in_valid = iv; b_in_data = d; b_out_ready = ordy; b_flush = fl;
    end
    @(negedge clk);
    if (sel == 0) begin
      sz = qa.size();
      chk("a_in_ready", a_in_ready, sz < 2);
      chk("a_out_valid", a_out_valid, sz != 0);
      chk("a_count", a_count, sz);
      if (sz != 0) chk("a_out_data", a_out_data, qa[0]);
`ifdef PIPE_STAGE_BUFFER_ORDER_EN
      if (sz != 0) chk("a_out_order", a_out_order, ord_a);
`endif
      if (fl) qa.delete();
      else begin
        if (sz != 0 && ordy) begin void'(qa.pop_front()); ord_a++; end
        if (iv && sz < 2) qa.push_back(d);
      end
    end else begin
      sz = qb.size();
      chk("b_in_ready", b_in_ready, sz < 3);
      chk("b_out_valid", b_out_valid, sz != 0);
      chk("b_count", b_count, sz);
      if (sz != 0) chk("b_out_data", b_out_data, qb[0]);
      if (fl) qb.delete();
      else begin
        if (sz != 0 && ordy) void'(qb.pop_front());
        if (iv && sz < 3) qb.push_back(d);
      end
    end
    @(posedge clk);
    #1;
    if (sel == 0) begin
      a_in_valid = 0; a_out_ready = 0; a_flush = 0;
    end else begin
      b_in_valid = 0; b_out_ready = 0; b_flush = 0;
    end
  endtask

  initial begin
    a_rst_n = 0; a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_in_data = '0;
    b_rst_n = 0; b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_count", a_count, 0);
    chk("rst_a_out_valid", a_out_valid, 0);
    chk("rst_a_in_ready", a_in_ready, 1);
    chk("rst_b_count", b_count, 0);
    chk("rst_b_out_valid", b_out_valid, 0);
    a_rst_n = 1;
    b_rst_n = 1;

    // Fill and stall, then full-with-dequeue, then flush, then streaming 1..8.
    add(1, 32'h11, 0, 0, 1);
    add(1, 32'h22, 0, 0, 2);
    for (int i = 0; i < 5; i++) add(0, 32'h0, 0, 0, 2);
    add(1, 32'h33, 1, 0, 1);
    add(1, 32'h33, 0, 0, 2);
    add(1, 32'hAA, 0, 1, 0);
    add(1, 32'hBB, 0, 0, 1);
    add(0, 32'h0, 1, 0, 0);
    add(1, 32'd1, 1, 0, 1);
    for (int i = 2; i <= 8; i++) add(1, 32'(i), 1, 0, 1);
    add(0, 32'h0, 1, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(0, tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
      chk($sformatf("tbl%0d_count", i), a_count, tbl[i].exp_cnt);
    end

    // DEPTH=3: seven words through the buffer, pointers wrap 2->0.
    cyc(1, 1, 32'h101, 0, 0);
    cyc(1, 1, 32'h102, 0, 0);
    cyc(1, 1, 32'h103, 0, 0);
    chk("b_full_count", b_count, 3);
    cyc(1, 1, 32'h104, 1, 0);
    chk("b_full_deq_count", b_count, 2);
    for (int i = 4; i <= 7; i++) cyc(1, 1, 32'h100 + 32'(i), 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 32'h0, 1, 0);
    chk("b_drained", b_count, 0);

    // Mid-cycle asynchronous reset with two held entries.
    cyc(1, 1, 32'h201, 0, 0);
    cyc(1, 1, 32'h202, 0, 0);
    #2;
    b_rst_n = 0;
    #1;
    chk("async_rst_count", b_count, 0);
    chk("async_rst_out_valid", b_out_valid, 0);
    chk("async_rst_in_ready", b_in_ready, 1);
    qb.delete();
    @(posedge clk);
    #1;
    b_rst_n = 1;
    cyc(1, 1, 32'h301, 0, 0);
    cyc(1, 0, 32'h0, 1, 0);

    // Order tags: three retirements, two flushed entries, one more retirement.
    a_rst_n = 0;
    @(posedge clk);
    #1;
    a_rst_n = 1;
    qa.delete();
    ord_a = 0;
    cyc(0, 1, 32'h401, 0, 0);
    cyc(0, 1, 32'h402, 0, 0);
    cyc(0, 0, 32'h0, 1, 0);
    cyc(0, 0, 32'h0, 1, 0);
    cyc(0, 1, 32'h403, 0, 0);
    cyc(0, 0, 32'h0, 1, 0);
    cyc(0, 1, 32'h404, 0, 0);
    cyc(0, 1, 32'h405, 0, 0);
    cyc(0, 0, 32'h0, 1, 1);
    cyc(0, 1, 32'h406, 0, 0);
    cyc(0, 0, 32'h0, 1, 0);
    chk("order_seq_empty", a_count, 0);
`ifdef PIPE_STAGE_BUFFER_ORDER_EN
    chk("order_after_four", a_out_order, 64'd4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
